console_text_buffer: RTL

//  Character-cell screen memory feeding the console renderer. It accepts a byte stream
//  (characters and control codes) on a valid/ready handshake and keeps a COLS x ROWS

---
 rtl/console_pkg.sv | 19 +
 rtl/text_ram.sv | 21 ++
 rtl/console_text_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared constants and state encoding for the console character-cell buffer.
package console_pkg;

   localparam int CELL_W = 8;
   localparam int CELL_H = 16;

   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_SPACE = 8'h20;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      RUN    = 2'd1,
      SCROLL = 2'd2
   } state_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port cell RAM: one write per cycle, registered read (old data on collision).
module text_ram #(
   parameter int DEPTH = 2400,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_pixel,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk_pixel) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/console_text_buffer.sv
// Character-cell screen memory with cursor, wrap and ring-buffer hardware scroll.
//
//  state  | meaning
//  CLEAR  | blank every cell, one per cycle; input stalled
//  RUN    | accept bytes, update cursor, write printable cells
//  SCROLL | blank the recycled physical row; input stalled
module console_text_buffer
   import console_pkg::*;
#(
   parameter int         COLS         = 80,
   parameter int         ROWS         = 30,
   parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
   input  logic       clk_pixel,
   input  logic       reset_n,
   input  logic [7:0] char_data,
   input  logic [7:0] char_attr,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [9:0] cx,
   input  logic [9:0] cy,
   output logic [7:0] character,
   output logic [7:0] attribute,
   output logic       busy
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int LCW   = 10 - $clog2(CELL_W);
   localparam int LRW   = 10 - $clog2(CELL_H);

   state_t         state;
   logic [AW-1:0]  clr_idx;
   logic [CW-1:0]  scr_idx;
   logic [RW-1:0]  scroll_row;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   logic [RW-1:0]  top_row;
   logic [RW-1:0]  frame_top;

   logic           we;
   logic [AW-1:0]  waddr;
   logic [15:0]    wdata;
   logic [AW-1:0]  raddr;
   logic [15:0]    rdata;

   function automatic logic [RW-1:0] wrap_row(input logic [RW:0] sum);
      logic [RW:0] r;
      r = (sum >= (RW+1)'(ROWS)) ? sum - (RW+1)'(ROWS) : sum;
      return r[RW-1:0];
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return AW'(r) * AW'(COLS) + AW'(c);
   endfunction

   logic accept, printable, do_newline;
   logic [RW-1:0] wr_prow;

   assign accept     = char_valid & char_ready;
   assign printable  = !(char_data inside {CH_LF, CH_CR, CH_BS, CH_FF});
   assign do_newline = (char_data == CH_LF) || (printable && col == CW'(COLS-1));
   assign wr_prow    = wrap_row({1'b0, top_row} + {1'b0, row});

   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = {DEFAULT_ATTR, CH_SPACE};
      case (state)
         CLEAR: begin
            we    = 1'b1;
            waddr = clr_idx;
         end
         SCROLL: begin
            we    = 1'b1;
            waddr = cell_addr(scroll_row, scr_idx);
         end
         RUN: begin
            we    = accept & printable;
            waddr = cell_addr(wr_prow, col);
            wdata = {char_attr, char_data};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         scr_idx    <= '0;
         scroll_row <= '0;
         row        <= '0;
         col        <= '0;
         top_row    <= '0;
         char_ready <= 1'b0;
         busy       <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_idx == AW'(CELLS-1)) begin
                  state      <= RUN;
                  char_ready <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            SCROLL: begin
               if (scr_idx == CW'(COLS-1)) begin
                  state      <= RUN;
                  char_ready <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  scr_idx <= scr_idx + CW'(1);
               end
            end
            RUN: begin
               if (accept) begin
                  if (char_data == CH_FF) begin
                     row        <= '0;
                     col        <= '0;
                     top_row    <= '0;
                     clr_idx    <= '0;
                     state      <= CLEAR;
                     char_ready <= 1'b0;
                     busy       <= 1'b1;
                  end else if (char_data == CH_CR) begin
                     col <= '0;
                  end else if (char_data == CH_BS) begin
                     if (col != '0) col <= col - CW'(1);
                  end else begin
                     col <= do_newline ? '0 : col + CW'(1);
                     // Scrolling recycles the old top line as the new blank bottom line.
                     if (do_newline) begin
                        if (row != RW'(ROWS-1)) begin
                           row <= row + RW'(1);
                        end else begin
                           scroll_row <= top_row;
                           top_row    <= wrap_row({1'b0, top_row} + (RW+1)'(1));
                           scr_idx    <= '0;
                           state      <= SCROLL;
                           char_ready <= 1'b0;
                           busy       <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               state      <= CLEAR;
               clr_idx    <= '0;
               char_ready <= 1'b0;
               busy       <= 1'b1;
            end
         endcase
      end
   end

   logic [LCW-1:0] lc;
   logic [LRW-1:0] lr;
   logic           frame_start, in_range, in_range_q;
   logic [RW-1:0]  view_top, rd_prow;

   assign lc          = cx[9:$clog2(CELL_W)];
   assign lr          = cy[9:$clog2(CELL_H)];
   assign frame_start = (cx == '0) && (cy == '0);
   // The first pixel of a frame already sees the newly latched top row.
   assign view_top    = frame_start ? top_row : frame_top;
   assign in_range    = (lr < LRW'(ROWS)) && (lc < LCW'(COLS));
   assign rd_prow     = wrap_row({1'b0, view_top} + (RW+1)'(lr[RW-1:0]));
   assign raddr       = in_range ? cell_addr(rd_prow, lc[CW-1:0]) : '0;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         frame_top  <= '0;
         in_range_q <= 1'b0;
      end else begin
         if (frame_start) frame_top <= top_row;
         in_range_q <= in_range;
      end
   end

   assign character = in_range_q ? rdata[7:0]  : CH_SPACE;
   assign attribute = in_range_q ? rdata[15:8] : 8'h00;

   logic unused_bits;
   assign unused_bits = ^{cx[$clog2(CELL_W)-1:0], cy[$clog2(CELL_H)-1:0]};

   text_ram #(.DEPTH(CELLS), .AW(AW)) u_text_ram (
      .clk_pixel (clk_pixel),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr     (raddr),
      .rdata     (rdata)
   );

endmodule
